gfx256_wr_combine: RTL
======================

Name: gfx256_wr_combine

Overview:
- Write-combining front end that sits directly upstream of the gfx256 Wishbone read/write master.
- Coalesces 64-bit pixel-side writes into one 256-bit line buffer and passes reads through.
- Drives the master's one-outstanding request interface: read_request/write_request, 256-bit address/sel/data. Consumes its data-ack pulse.
- Cuts bus transactions for raster/blit writes that touch adjacent pixels in the same 32-byte line.

Parameters:
- TIMEOUT, 16: idle cycles after the last merged write before an automatic flush; 0 disables the timer.
- TW, 8: width of the timeout counter; must satisfy TIMEOUT < 2**TW.

Ports:
- clk_i  in  1  master clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  pixel-side request valid
- we_i  in  1  1 = write, 0 = read
- adr_i  in  29  byte address [31:3]
- sel_i  in  8  byte lane enables
- dat_i  in  64  write data
- rdy_o  out  1  request accepted this cycle when req_i & rdy_o
- rdat_o  out  64  read data
- rack_o  out  1  one-cycle read-data-valid pulse
- flush_i  in  1  force flush of a valid line
- busy_o  out  1  line valid or bus operation in progress
- read_request_o  out  1  to master: read pulse
- write_request_o  out  1  to master: write pulse
- texture_addr_o  out  27  line address [31:5]
- texture_sel_o  out  32  byte enables
- texture_dat_o  out  256  line write data
- texture_dat_i  in  256  line read data from master
- texture_data_ack_i  in  1  master completion pulse (ack or err)

Behaviour:
- Reset (async, rst_i=1): all outputs 0; line_v=0, line_sel=0, line_dat=0, timer=0, state=IDLE. Any outstanding bus op is abandoned; an ack arriving after reset release in IDLE is ignored.
- State register: IDLE, WISSUE, WWAIT, RISSUE, RWAIT.
- Line buffer: line_v, line_adr[31:5], line_sel[31:0], line_dat[255:0]. The lane for adr_i[4:3]=k is bytes 8k..8k+7.
- rdy_o is combinational and is 1 only in IDLE with no flush condition pending. The conditions that hold it low are:
  - flush_i
  - timer expiry
  - a write to another line while line_v
  - a read to the same line while line_v
- Write accept (IDLE, req_i, we_i, rdy_o):
  - Merge dat_i bytes where sel_i=1 into line_dat; OR the lane sel into line_sel.
  - Set line_v, load line_adr, reset the timer.
  - sel_i=0: accepted, no state change.
- Write miss (line_v, adr_i[31:5]!=line_adr): flush first; the request is accepted in the first IDLE cycle after the flush completes.
- Full line: when line_sel becomes all-ones after a merge, go to WISSUE on the next cycle.
- Timer:
  - Increments each IDLE cycle while line_v and no write is accepted.
  - At count==TIMEOUT-1 (TIMEOUT>0), the next cycle enters WISSUE.
- flush_i in IDLE: with line_v, go to WISSUE; with !line_v, no effect.
- WISSUE: one-cycle pulse of write_request_o with addr=line_adr, sel=line_sel, dat=line_dat; then WWAIT.
- WWAIT: on texture_data_ack_i, clear line_v, line_sel and the timer; return to IDLE.
- Read accept (IDLE, !we_i, rdy_o):
  - Read to another line, or !line_v: accepted immediately; latch adr_i[4:3]; go to RISSUE.
  - Read to the same line while line_v: flush first.
- RISSUE: one-cycle read_request_o, texture_sel_o=all-ones, addr=request line; then RWAIT.
- RWAIT: on ack, rdat_o <= texture_dat_i lane k and rack_o=1 for exactly one cycle (registered, the cycle after ack); IDLE.
- Exactly one request pulse per bus op; never issue while in WWAIT/RWAIT.
- Simultaneous events:
  - flush_i with a hitting write: the flush wins and the write waits.
  - Timer expiry and req_i in the same cycle: the flush wins.
- An ack in IDLE/WISSUE/RISSUE is ignored.
- busy_o = line_v | (state!=IDLE).

Optional Feature:
- Macro: GFX256_WRC_READ_HIT_EN.
- Defined: a same-line read whose requested bytes (sel_i in lane k) are all set in line_sel is served from line_dat without flushing. rdy_o=1; rack_o pulses the next cycle. Bytes with sel_i=0 return 0. A partial-coverage hit still flushes then reads.
- Undefined: every same-line read flushes first.

Test Plan:
- Four writes to 0x1000, 0x1008, 0x1010, 0x1018, each with sel=0xFF and distinct data -> exactly one write_request_o: addr 0x1000>>5, sel 0xFFFFFFFF, data concatenated low-to-high; the pulse comes one cycle after the 4th accept.
- Write 0x2000 sel=0x0F, then idle with TIMEOUT=16 -> write_request_o 17 cycles after accept, sel=0x0000000F; busy_o drops the cycle after the ack.
- Write 0x3000, then write 0x3020 -> rdy_o low on the second request; flush of line 0x3000 with sel 0xFF; second write accepted the cycle after the ack.
- Read 0x4018 with no line valid; master returns data with byte 24=0xAA -> read_request_o once, rack_o one cycle after ack, rdat_o[7:0]=0xAA.
- Write 0x5000 sel=0xFF, then read 0x5000 -> without the macro: flush then read, two bus ops. With GFX256_WRC_READ_HIT_EN: no bus op, rdat_o = written data.
- rst_i asserted during WWAIT, ack arrives after release -> no rack_o, no request, busy_o=0.

Source files
------------

// File: rtl/gfx256_wr_combine.sv
// gfx256_wr_combine: write-combining front end for the gfx256 Wishbone master.
// Pixel-side 64-bit writes are merged into a single 256-bit line buffer that
// is flushed as one bus write when it fills, times out, is forced by flush_i,
// or must make room for a different line. Reads pass through as line reads.
// Optional build macro GFX256_WRC_READ_HIT_EN: same-line reads whose bytes are
// all present in the line buffer are answered locally without a flush.
//
// Handshake: a pixel request is taken on a rising clk_i edge when req_i and
// rdy_o are both high; read data returns later as a one-cycle rack_o pulse.
// Toward the master, each bus op is a single request pulse followed by
// waiting for exactly one texture_data_ack_i pulse.
module gfx256_wr_combine #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [28:0]  adr_i,
    input  logic [7:0]   sel_i,
    input  logic [63:0]  dat_i,
    output logic         rdy_o,
    output logic [63:0]  rdat_o,
    output logic         rack_o,
    input  logic         flush_i,
    output logic         busy_o,
    output logic         read_request_o,
    output logic         write_request_o,
    output logic [26:0]  texture_addr_o,
    output logic [31:0]  texture_sel_o,
    output logic [255:0] texture_dat_o,
    input  logic [255:0] texture_dat_i,
    input  logic         texture_data_ack_i
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WISSUE = 3'd1,
        WWAIT  = 3'd2,
        RISSUE = 3'd3,
        RWAIT  = 3'd4
    } state_t;

    // Last timer value before an automatic flush; unused when TIMEOUT is 0.
    localparam logic [TW-1:0] TMAX     = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam bit            TIMER_EN = (TIMEOUT > 0);

    state_t         state_q,    state_d;
    logic           line_v_q,   line_v_d;
    logic [26:0]    line_adr_q, line_adr_d;
    logic [31:0]    line_sel_q, line_sel_d;
    logic [255:0]   line_dat_q, line_dat_d;
    logic [TW-1:0]  timer_q,    timer_d;
    logic [26:0]    rd_adr_q,   rd_adr_d;
    logic [1:0]     rd_lane_q,  rd_lane_d;
    logic [63:0]    rdat_q,     rdat_d;
    logic           rack_q,     rack_d;

    logic [26:0]    req_line;
    logic [1:0]     req_lane;
    logic           idle;
    logic           same_line;
    logic           timer_exp;
    logic           wr_miss;
    logic           rd_hit;
    logic           rd_flush;
    logic           hold;
    logic           flush_go;
    logic           rdy;
    logic           wr_acc;
    logic           rd_acc;
    logic           rd_phase;

    assign req_line  = adr_i[28:2];
    assign req_lane  = adr_i[1:0];
    assign idle      = (state_q == IDLE);
    assign same_line = line_v_q && (req_line == line_adr_q);
    assign timer_exp = TIMER_EN && line_v_q && (timer_q == TMAX);
    assign wr_miss   = req_i && we_i && line_v_q && (req_line != line_adr_q);

`ifdef GFX256_WRC_READ_HIT_EN
    logic [7:0]  lane_sel;
    logic [63:0] hit_dat;

    // Coverage of the addressed lane and the masked local read data for hits.
    always_comb begin
        lane_sel = line_sel_q[{req_lane, 3'b000} +: 8];
        hit_dat  = '0;
        for (int b = 0; b < 8; b++) begin
            if (sel_i[b]) begin
                hit_dat[8*b +: 8] = line_dat_q[{req_lane, b[2:0], 3'b000} +: 8];
            end
        end
    end

    assign rd_hit = req_i && !we_i && same_line && ((sel_i & ~lane_sel) == 8'h00);
`else
    assign rd_hit = 1'b0;
`endif

    // A same-line read must see the merged bytes, so it waits for the flush.
    assign rd_flush = req_i && !we_i && same_line && !rd_hit;
    assign hold     = flush_i || timer_exp || wr_miss || rd_flush;
    assign flush_go = idle && line_v_q && hold;
    assign rdy      = idle && !hold && !rst_i;
    assign wr_acc   = req_i && we_i && rdy;
    assign rd_acc   = req_i && !we_i && rdy;
    assign rd_phase = (state_q == RISSUE) || (state_q == RWAIT);

    // Next-state, line-buffer merge, timer and read-return logic.
    always_comb begin
        state_d    = state_q;
        line_v_d   = line_v_q;
        line_adr_d = line_adr_q;
        line_sel_d = line_sel_q;
        line_dat_d = line_dat_q;
        timer_d    = timer_q;
        rd_adr_d   = rd_adr_q;
        rd_lane_d  = rd_lane_q;
        rdat_d     = rdat_q;
        rack_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (line_v_q && !wr_acc) begin
                    timer_d = timer_q + 1'b1;
                end
                if (flush_go) begin
                    state_d = WISSUE;
                end else if (wr_acc && (sel_i != 8'h00)) begin
                    for (int b = 0; b < 8; b++) begin
                        if (sel_i[b]) begin
                            line_dat_d[{req_lane, b[2:0], 3'b000} +: 8] = dat_i[8*b +: 8];
                            line_sel_d[{req_lane, b[2:0]}] = 1'b1;
                        end
                    end
                    line_v_d   = 1'b1;
                    line_adr_d = req_line;
                    timer_d    = '0;
                    if (&line_sel_d) begin
                        state_d = WISSUE;
                    end
                end else if (rd_acc && rd_hit) begin
`ifdef GFX256_WRC_READ_HIT_EN
                    rdat_d = hit_dat;
                    rack_d = 1'b1;
`endif
                end else if (rd_acc) begin
                    rd_adr_d  = req_line;
                    rd_lane_d = req_lane;
                    state_d   = RISSUE;
                end
            end
            WISSUE: begin
                state_d = WWAIT;
            end
            WWAIT: begin
                if (texture_data_ack_i) begin
                    line_v_d   = 1'b0;
                    line_sel_d = '0;
                    timer_d    = '0;
                    state_d    = IDLE;
                end
            end
            RISSUE: begin
                state_d = RWAIT;
            end
            RWAIT: begin
                if (texture_data_ack_i) begin
                    rdat_d  = texture_dat_i[{rd_lane_q, 6'b000000} +: 64];
                    rack_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and line-buffer registers; reset abandons any bus op in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            line_v_q   <= 1'b0;
            line_adr_q <= '0;
            line_sel_q <= '0;
            line_dat_q <= '0;
            timer_q    <= '0;
            rd_adr_q   <= '0;
            rd_lane_q  <= '0;
            rdat_q     <= '0;
            rack_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_v_q   <= line_v_d;
            line_adr_q <= line_adr_d;
            line_sel_q <= line_sel_d;
            line_dat_q <= line_dat_d;
            timer_q    <= timer_d;
            rd_adr_q   <= rd_adr_d;
            rd_lane_q  <= rd_lane_d;
            rdat_q     <= rdat_d;
            rack_q     <= rack_d;
        end
    end

    assign rdy_o           = rdy;
    assign rdat_o          = rdat_q;
    assign rack_o          = rack_q;
    assign busy_o          = line_v_q || !idle;
    assign write_request_o = (state_q == WISSUE);
    assign read_request_o  = (state_q == RISSUE);
    assign texture_addr_o  = rd_phase ? rd_adr_q : line_adr_q;
    assign texture_sel_o   = rd_phase ? 32'hFFFF_FFFF : line_sel_q;
    assign texture_dat_o   = line_dat_q;

endmodule
